// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweep sequencer for a small combinational gate.
// Optional per-vector capture of the sampled output enabled by GATE_SWEEP_YMAP_EN.
module gate_sweep_ctrl #(
    parameter int                  N      = 3,
    parameter int                  HOLD   = 5,
    parameter logic [(1<<N)-1:0]   EXPECT = 8'b1000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   y_in,
    output logic [N-1:0]           vec,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N:0]             err_cnt,
    output logic                   err_valid,
    output logic [N-1:0]           first_err,
    output logic [(1<<N)-1:0]      y_map
);

    localparam int             NV        = 1 << N;
    localparam logic [7:0]     HOLD_LAST = 8'(HOLD - 1);
    localparam logic [N-1:0]   VEC_LAST  = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state;
    logic [7:0]     r_cnt;
    logic [N-1:0]   r_vec;
    logic           r_busy;
    logic           r_done;
    logic           r_pass;
    logic [N:0]     r_err_cnt;
    logic           r_err_valid;
    logic [N-1:0]   r_first_err;
    logic           w_mismatch;

    assign w_mismatch = (y_in != EXPECT[r_vec]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_vec       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_err_valid <= 1'b0;
            r_first_err <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_vec       <= '0;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_err_cnt   <= '0;
                        r_err_valid <= 1'b0;
                        r_first_err <= '0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else if (r_cnt == HOLD_LAST) begin
                        if (w_mismatch) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                            if (!r_err_valid) begin
                                r_first_err <= r_vec;
                                r_err_valid <= 1'b1;
                            end
                        end
                        r_cnt <= '0;
                        if (r_vec == VEC_LAST) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            // pass must account for the final sample landing this same edge
                            r_pass  <= !w_mismatch && (r_err_cnt == '0);
                        end else begin
                            r_vec <= r_vec + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef GATE_SWEEP_YMAP_EN
    logic [NV-1:0]  r_y_map;
    logic           w_sample;

    assign w_sample = (r_state == S_RUN) && !abort && (r_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_map <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_y_map <= '0;
        end else if (w_sample) begin
            r_y_map[r_vec] <= y_in;
        end
    end

    assign y_map = r_y_map;
`else
    assign y_map = '0;
`endif

    assign vec       = r_vec;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_cnt   = r_err_cnt;
    assign err_valid = r_err_valid;
    assign first_err = r_first_err;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized self-checking bench for gate_sweep_ctrl against a truth-table reference model.
// Expectations for y_map follow GATE_SWEEP_YMAP_EN.
module tb_gate_sweep_ctrl;

    localparam int         N      = 3;
    localparam int         HOLD   = 5;
    localparam int         NV     = 8;
    localparam logic [7:0] EXP_TT = 8'b1000_0000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] tt    = 8'h00;
    logic       y_in;
    logic [2:0] vec;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_cnt;
    logic       err_valid;
    logic [2:0] first_err;
    logic [7:0] y_map;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // gate under test modelled as a lookup on the driven vector
    assign y_in = tt[vec];

    gate_sweep_ctrl #(
        .N      (N),
        .HOLD   (HOLD),
        .EXPECT (EXP_TT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .y_in      (y_in),
        .vec       (vec),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .err_valid (err_valid),
        .first_err (first_err),
        .y_map     (y_map)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: compare the first nsampled truth-table entries with the expected table
    task automatic check_results(input string tag, input logic [7:0] t, input int nsampled,
                                 input bit completed);
        int         e_cnt;
        int         e_first;
        logic [7:0] e_map;
        logic [7:0] ex;
        ex      = EXP_TT;
        e_cnt   = 0;
        e_first = 0;
        e_map   = 8'h00;
        for (int k = 0; k < nsampled; k++) begin
            if (t[k] != ex[k]) begin
                if (e_cnt == 0) e_first = k;
                e_cnt++;
            end
            e_map[k] = t[k];
        end
        check_eq({tag, "_err_cnt"},   32'(err_cnt),   32'(e_cnt));
        check_eq({tag, "_err_valid"}, 32'(err_valid), 32'(e_cnt != 0));
        if (e_cnt != 0) check_eq({tag, "_first_err"}, 32'(first_err), 32'(e_first));
        check_eq({tag, "_pass"},      32'(pass),      32'(completed && (e_cnt == 0)));
`ifdef GATE_SWEEP_YMAP_EN
        check_eq({tag, "_y_map"},     32'(y_map),     32'(e_map));
`else
        check_eq({tag, "_y_map"},     32'(y_map),     32'(0));
`endif
    endtask

    task automatic sweep(input string tag, input logic [7:0] t, input int restart_at,
                         input int abort_at, input bit abort_with_start);
        int cyc;
        int nsamp;
        bit vec_ok;
        bit saw_done;
        tt = t;
        @(negedge clk);
        start = 1'b1;
        abort = abort_with_start;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        cyc    = 0;
        vec_ok = (vec == 3'd0) && busy && !done;
        while (cyc < 100) begin
            if (cyc == restart_at) start = 1'b1;
            if (cyc == abort_at)   abort = 1'b1;
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            cyc++;
            if (done) break;
            if (abort_at >= 0 && cyc > abort_at) break;
            if (vec !== 3'(cyc / HOLD) || !busy) vec_ok = 1'b0;
        end
        if (abort_at < 0) begin
            check_eq({tag, "_done_cycle"}, 32'(cyc), 32'(NV * HOLD));
            check_eq({tag, "_vec_seq"},    32'(vec_ok), 32'(1));
            check_eq({tag, "_busy_at_done"}, 32'(busy), 32'(0));
            check_eq({tag, "_vec_last"},   32'(vec), 32'(NV - 1));
            check_results(tag, t, NV, 1'b1);
            @(negedge clk);
            check_eq({tag, "_done_pulse"}, 32'(done), 32'(0));
            repeat (3) @(negedge clk);
            check_eq({tag, "_vec_hold"},   32'(vec), 32'(NV - 1));
            check_results({tag, "_held"}, t, NV, 1'b1);
        end else begin
            // abort seen at edge E0+abort_at+1; samples before that edge survive
            nsamp = abort_at / HOLD;
            check_eq({tag, "_abort_busy"}, 32'(busy), 32'(0));
            check_eq({tag, "_abort_vec"},  32'(vec),  32'(nsamp));
            saw_done = done;
            repeat (50) begin
                @(negedge clk);
                if (done || busy) saw_done = 1'b1;
            end
            check_eq({tag, "_abort_no_done"}, 32'(saw_done), 32'(0));
            check_results({tag, "_abort"}, t, nsamp, 1'b0);
        end
    endtask

    initial begin
        int gap;
        int ab;
        int rs;
        logic [7:0] rt;
        bit saw;

        repeat (2) @(negedge clk);
        check_eq("rst_vec",   32'(vec),  32'(0));
        check_eq("rst_busy",  32'(busy), 32'(0));
        check_eq("rst_done",  32'(done), 32'(0));
        check_results("rst", 8'h00, 0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        sweep("and",     8'h80, -1, -1, 1'b0);
        sweep("or",      8'hFE, -1, -1, 1'b0);
        sweep("stuck0",  8'h00, -1, -1, 1'b0);
        sweep("restart", 8'hFE, 12, -1, 1'b0);
        sweep("abort17", 8'hFE, -1, 17, 1'b0);
        sweep("after_abort", 8'h80, -1, -1, 1'b0);
        sweep("abort_first", 8'h7F, -1, 4, 1'b0);
        sweep("abort_last",  8'h00, -1, 39, 1'b0);
        sweep("start_abort", 8'hFE, -1, -1, 1'b1);

        // asynchronous reset in the middle of a sweep
        tt = 8'hFE;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (23) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_vec",  32'(vec),  32'(0));
        check_eq("midrst_busy", 32'(busy), 32'(0));
        check_eq("midrst_done", 32'(done), 32'(0));
        check_results("midrst", 8'h00, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (done || busy || vec != 3'd0) saw = 1'b1;
        end
        check_eq("postrst_idle", 32'(saw), 32'(0));

        for (int i = 0; i < 10; i++) begin
            rt  = 8'($urandom);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 39)) : -1;
            rs = (ab < 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 39)) : -1;
            sweep($sformatf("rnd%0d", i), rt, rs, ab, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
